fetch_unit: RTL and testbench

Instruction-fetch stage of the LittleChip RISC-V core: owns the PC, drives the synchronous instruction memory, and presents `{inst, pc, valid}` to the decode stage. It accepts a registered redirect from decode, taken from decode's `ctrl_pc_src` and `branch_pc_new`, and a stall from the hazard logic. It squashes the one wrong-path fetch that follows a redirect. Invalid slots are presented to decode as a canonical NOP, so decode's control unit emits no side effects.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the LittleChip fetch stage.
//   fetch_state_e    - fetch FSM state encoding (boot, run, squash)
//   DEFAULT_RESET_PC - first fetch address after reset (also used by boot logic)
//   DEFAULT_NOP_INST - canonical NOP, addi x0,x0,0, shown to decode on bubbles
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives a synchronous-read
// instruction memory and presents {inst, pc, valid} to decode.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_en         - IMEM read enable (= !rst)
//   imem_addr       - byte address issued this cycle (combinational)
//   imem_dout       - IMEM data, valid one cycle after imem_addr
//   stall           - decode cannot accept; hold current instruction
//   redirect_valid  - taken branch/jump from decode
//   redirect_pc     - redirect target (low two bits ignored)
//   id_inst, id_pc  - instruction and its PC to decode (NOP when invalid)
//   id_valid        - id_inst/id_pc are a real on-path instruction
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(DEFAULT_NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_dout,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic                  id_valid
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] redir_q, redir_d;
    logic [PC_WIDTH-1:0] pc_plus4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_d    = redir_q;
        pc_plus4   = fetch_pc_q + PC_WIDTH'(4);

        imem_en    = !rst;
        imem_addr  = RESET_PC;
        id_valid   = 1'b0;
        id_inst    = NOP_INST;
        id_pc      = fetch_pc_q;

        unique case (state_q)
            S_BOOT: begin
                imem_addr  = RESET_PC;
                fetch_pc_d = RESET_PC;
                state_d    = S_RUN;
            end
            S_RUN: begin
                id_valid = 1'b1;
                id_inst  = imem_dout;
                if (stall) begin
                    // Re-issue the current word so it reappears unchanged.
                    imem_addr = fetch_pc_q;
                end else if (redirect_valid) begin
                    // Sequential fetch still goes out; it is dropped in S_SQUASH.
                    imem_addr = pc_plus4;
                    redir_d   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
                    state_d   = S_SQUASH;
                end else begin
                    imem_addr  = pc_plus4;
                    fetch_pc_d = pc_plus4;
                end
            end
            S_SQUASH: begin
                imem_addr  = redir_q;
                fetch_pc_d = redir_q;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Outputs sit at their reset values for every cycle rst is high,
        // including the first one, before the state register has reset.
        if (rst) begin
            imem_addr = RESET_PC;
            id_valid  = 1'b0;
            id_inst   = NOP_INST;
            id_pc     = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            redir_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_q    <= redir_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A synchronous IMEM model
// returns a hashed word per address; a slot-level reference model predicts what
// decode should see each cycle.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_dout, id_inst, id_pc;
    logic        imem_en, id_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH  (32),
        .INST_WIDTH(32),
        .RESET_PC  (RPC),
        .NOP_INST  (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_valid      (id_valid)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    initial imem_dout = 32'h0;
    always @(posedge clk) if (imem_en) imem_dout <= word_at(imem_addr);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the slot decode currently sees, plus the PC the next
    // valid slot will carry after a bubble.
    bit          m_valid  = 1'b0;
    logic [31:0] m_pc     = RPC;
    logic [31:0] m_resume = RPC;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rp);
        logic [31:0] e_addr;
        @(negedge clk);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        if (r)             e_addr = RPC;
        else if (!m_valid) e_addr = m_resume;
        else if (s)        e_addr = m_pc;
        else               e_addr = m_pc + 32'd4;
        check("imem_en",   32'(imem_en),  32'(!r));
        check("imem_addr", imem_addr,     e_addr);
        check("id_valid",  32'(id_valid), r ? 32'd0 : 32'(m_valid));
        check("id_pc",     id_pc,         r ? RPC : m_pc);
        check("id_inst",   id_inst,       (r || !m_valid) ? NOP : word_at(m_pc));
        @(posedge clk);
        if (r) begin
            m_valid  = 1'b0;
            m_pc     = RPC;
            m_resume = RPC;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_pc    = m_resume;
        end else if (s) begin
            // held
        end else if (rv) begin
            m_valid  = 1'b0;
            m_resume = rp & ~32'h3;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset, with stall/redirect noise that must be ignored.
        step(1, 0, 0, 32'h0);
        step(1, 1, 1, 32'h80);
        step(1, 0, 0, 32'h0);

        // Boot bubble, then free-run 0x0, 0x4, redirect at 0x8 to 0x40.
        step(0, 1, 1, 32'h100);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 1, 32'h40);
        step(0, 1, 1, 32'h200);
        step(0, 0, 1, 32'h10);

        // Bubble, then 0x10 stalled for 3 cycles, then release to 0x14.
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);

        // Stall+redirect twice at 0x14, then redirect alone.
        step(0, 1, 1, 32'h80);
        step(0, 1, 1, 32'h80);
        step(0, 0, 1, 32'h80);
        step(0, 0, 0, 32'h0);

        // Misaligned target 0x43 lands on 0x40.
        step(0, 0, 1, 32'h43);
        step(0, 0, 0, 32'h0);

        // PC wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
        step(0, 0, 1, 32'hFFFF_FFF8);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);

        // Reset while squashing: restart at RESET_PC, not the latched target.
        step(0, 0, 1, 32'h200);
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          r, s, rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, s, rv, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
